// File: rtl/reg_shift_n_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_shift_n_if
// Description : Command/status bundle for the reg_shift_n shift register.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_shift_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             Load;
    logic [WIDTH-1:0] D;
    logic [1:0]       Mode;
    logic             Shift_In;
    logic             Shift;
    logic             Start;
    logic [CNT_W-1:0] Count;
    logic [WIDTH-1:0] Data_Out;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;

    modport master (
        output Load, D, Mode, Shift_In, Shift, Start, Count,
        input  Data_Out, Shift_Out, Busy, Done
    );

    modport slave (
        input  Load, D, Mode, Shift_In, Shift, Start, Count,
        output Data_Out, Shift_Out, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/reg_shift_n.sv
`default_nettype none
// ============================================================================
// Module      : reg_shift_n
// Description : WIDTH-bit load/shift register with a counted burst-shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_shift_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    reg_shift_n_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_shift_out;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic             r_sin;

    logic [1:0]       w_mode;
    logic             w_sin;
    logic [WIDTH:0]   w_step;

    // Returns {bit shifted out, next register value}.
    function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       m,
                                              input logic             s);
        case (m)
            2'b00:   f_step = {v[0], s, v[WIDTH-1:1]};
            2'b01:   f_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            2'b10:   f_step = {v[WIDTH-1], v[WIDTH-2:0], s};
            default: f_step = {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    // Bursts use the Mode/Shift_In captured at Start, not the live inputs.
    always_comb begin
        w_mode = (r_state == RUN) ? r_mode : bus.Mode;
        w_sin  = (r_state == RUN) ? r_sin  : bus.Shift_In;
        w_step = f_step(r_data, w_mode, w_sin);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_shift_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_mode      <= 2'b00;
            r_sin       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Load) begin
                        r_data <= bus.D;
                    end else if (bus.Start) begin
                        r_mode <= bus.Mode;
                        r_sin  <= bus.Shift_In;
                        if (bus.Count == c_CNT_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= bus.Count;
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end else if (bus.Shift) begin
                        r_shift_out <= w_step[WIDTH];
                        r_data      <= w_step[WIDTH-1:0];
                    end
                end
                RUN: begin
                    if (bus.Load) begin
                        // Abort: no completion pulse.
                        r_data  <= bus.D;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_shift_out <= w_step[WIDTH];
                        r_data      <= w_step[WIDTH-1:0];
                        r_cnt       <= r_cnt - c_CNT_ONE;
                        if (r_cnt == c_CNT_ONE) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Data_Out  = r_data;
    assign bus.Shift_Out = r_shift_out;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_shift_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_shift_n
// Description : Directed vector bench for reg_shift_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_shift_n;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    reg_shift_n_if #(.WIDTH(8), .CNT_W(4)) bus ();

    reg_shift_n #(.WIDTH(8), .CNT_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       load;
        logic [7:0] d;
        logic [1:0] mode;
        logic       sin;
        logic       shift;
        logic       start;
        logic [3:0] count;
        logic [7:0] exp_data;
        logic       exp_so;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Load = 0; bus.D = 8'h00; bus.Mode = 2'b00; bus.Shift_In = 0;
        bus.Shift = 0; bus.Start = 0; bus.Count = 4'd0;
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic so,
                             input logic busy, input logic done);
        check({name, ".data"}, 32'(bus.Data_Out), 32'(d));
        check({name, ".so"},   32'(bus.Shift_Out), 32'(so));
        check({name, ".busy"}, 32'(bus.Busy), 32'(busy));
        check({name, ".done"}, 32'(bus.Done), 32'(done));
    endtask

    initial begin
        int busy_cycles;
        logic [7:0] exp_arr[3];
        n_checks = 0;
        n_fail   = 0;

        //           load d      mode  sin sh st cnt   data   so busy done
        vecs[0] = '{1'b1, 8'hA5, 2'b00, 0, 0, 0, 4'd0, 8'hA5, 0, 0, 0};
        vecs[1] = '{1'b0, 8'h00, 2'b01, 0, 1, 0, 4'd0, 8'hD2, 1, 0, 0};
        vecs[2] = '{1'b0, 8'h00, 2'b00, 0, 1, 0, 4'd0, 8'h69, 0, 0, 0};
        vecs[3] = '{1'b0, 8'h00, 2'b10, 1, 1, 0, 4'd0, 8'hD3, 0, 0, 0};
        vecs[4] = '{1'b0, 8'h00, 2'b11, 0, 1, 0, 4'd0, 8'hE9, 1, 0, 0};
        vecs[5] = '{1'b0, 8'h00, 2'b11, 0, 0, 0, 4'd0, 8'hE9, 1, 0, 0};
        vecs[6] = '{1'b1, 8'h00, 2'b11, 0, 1, 0, 4'd0, 8'h00, 1, 0, 0};
        vecs[7] = '{1'b0, 8'h00, 2'b00, 0, 0, 1, 4'd0, 8'h00, 1, 0, 1};
        vecs[8] = '{1'b0, 8'h00, 2'b00, 0, 0, 0, 4'd0, 8'h00, 1, 0, 0};

        idle_inputs();
        Reset = 1'b1;
        #1;
        check_out("reset", 8'h00, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.Load = vecs[i].load;  bus.D = vecs[i].d;
            bus.Mode = vecs[i].mode;  bus.Shift_In = vecs[i].sin;
            bus.Shift = vecs[i].shift; bus.Start = vecs[i].start;
            bus.Count = vecs[i].count;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_so,
                      vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Arithmetic-right burst of 3 on A5; live Mode changes are ignored.
        idle_inputs(); bus.Load = 1; bus.D = 8'hA5; step();
        idle_inputs(); bus.Start = 1; bus.Mode = 2'b01; bus.Count = 4'd3; step();
        check_out("sra.start", 8'hA5, 1, 1, 0);
        idle_inputs(); bus.Mode = 2'b10; bus.Shift_In = 1;
        exp_arr[0] = 8'hD2; exp_arr[1] = 8'hE9; exp_arr[2] = 8'hF4;
        busy_cycles = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sra.data%0d", i), 32'(bus.Data_Out), 32'(exp_arr[i]));
            check($sformatf("sra.done%0d", i), 32'(bus.Done), (i == 2) ? 32'd1 : 32'd0);
            if (bus.Busy) busy_cycles++;
        end
        check("sra.so", 32'(bus.Shift_Out), 32'd1);
        check("sra.busy_cycles", 32'(busy_cycles), 32'd3);
        step();
        check("sra.done_after", 32'(bus.Done), 32'd0);

        // Rotate by WIDTH returns the original value.
        idle_inputs(); bus.Load = 1; bus.D = 8'h3C; step();
        idle_inputs(); bus.Start = 1; bus.Mode = 2'b11; bus.Count = 4'd8; step();
        idle_inputs();
        busy_cycles = bus.Busy ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.Busy) busy_cycles++;
        end
        check_out("rot8", 8'h3C, 0, 0, 1);
        check("rot8.busy_cycles", 32'(busy_cycles), 32'd8);

        // Single left shifts with fill bit 1.
        idle_inputs(); bus.Load = 1; bus.D = 8'h81; step();
        idle_inputs(); bus.Mode = 2'b10; bus.Shift_In = 1; bus.Shift = 1; step();
        check_out("shl1", 8'h03, 1, 0, 0);
        step();
        check_out("shl2", 8'h07, 0, 0, 0);

        // Load aborts a burst without Done.
        idle_inputs(); bus.Load = 1; bus.D = 8'hF0; step();
        idle_inputs(); bus.Start = 1; bus.Count = 4'd5; step();
        idle_inputs(); step(); step();
        check_out("abort.mid", 8'h3C, 0, 1, 0);
        bus.Load = 1; bus.D = 8'h5A; step();
        check_out("abort", 8'h5A, 0, 0, 0);
        idle_inputs(); step();
        check("abort.nodone", 32'(bus.Done), 32'd0);

        // Start beats Shift in the same cycle.
        bus.Start = 1; bus.Shift = 1; bus.Mode = 2'b11; bus.Count = 4'd2; step();
        check_out("startshift", 8'h5A, 0, 1, 0);
        idle_inputs(); step();
        check("ss.data1", 32'(bus.Data_Out), 32'h2D);
        step();
        check_out("ss.end", 8'h96, 1, 0, 1);

        // Start accepted in the Done cycle.
        bus.Start = 1; bus.Mode = 2'b11; bus.Count = 4'd1; step();
        check_out("bkb.start", 8'h96, 1, 1, 0);
        idle_inputs(); step();
        check_out("bkb.end", 8'h4B, 0, 0, 1);

        // Asynchronous reset mid-burst.
        bus.Load = 1; bus.D = 8'hFF; step();
        idle_inputs(); bus.Start = 1; bus.Count = 4'd5; step();
        idle_inputs(); step();
        #2;
        Reset = 1'b1;
        #1;
        check_out("areset", 8'h00, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        step(); step();
        check_out("areset.quiet", 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
